// File: rtl/hbit_serializer_pkg.sv
// Shared definitions for hbit_serializer.
// Contents: state encoding shared by the serializer FSM and anything
// that decodes its state (IDLE=0, SHIFT=1, PARITY=2, DONE=3).
// Optional feature macro: HBIT_SERIALIZER_PARITY_EN (PARITY state used only then).
package hbit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/hbit_tick.sv
// Bit-period divider for hbit_serializer.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-high reset
//   enable  - count while high; counter held at 0 while low
//   tick_c  - combinational, high on the last cycle of each bit period
module hbit_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned DW = $clog2(CLKS_PER_BIT + 1);

  logic [DW-1:0] div_cnt;

  assign tick_c = enable && (div_cnt == DW'(CLKS_PER_BIT - 1));

  // Counts 0..CLKS_PER_BIT-1 and wraps; idle periods restart it at 0.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/hbit_serializer.sv
// Parallel-to-serial drain for stored words.
// Captures a WIDTH-bit word on an accepted load and shifts it out one bit
// per CLKS_PER_BIT cycles, LSB or MSB first, then pulses done.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   in, load          - word and start strobe (accepted when load && ready)
//   ready             - idle, able to accept load
//   out, out_valid    - serial bit and its qualifier (out=0 when not valid)
//   busy              - transfer in progress, including the done cycle
//   done              - one-cycle pulse after the last bit period
// Optional feature macro: HBIT_SERIALIZER_PARITY_EN appends an even-parity bit.
module hbit_serializer #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  import hbit_serializer_pkg::*;

  localparam int unsigned BW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_shift;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             out_n, out_valid_n, busy_n, done_n, ready_n;
  logic             tick_c;
`ifdef HBIT_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  // Bit that goes on the line first for a given register image.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  hbit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable ((state == ST_SHIFT) || (state == ST_PARITY)),
    .tick_c (tick_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next-cycle output values.
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bit_cnt_n   = bit_cnt;
    out_n       = 1'b0;
    out_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    ready_n     = 1'b0;
`ifdef HBIT_SERIALIZER_PARITY_EN
    par_n       = par;
`endif
    case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (load) begin
          state_n     = ST_SHIFT;
          sr_n        = in;
          bit_cnt_n   = '0;
          out_n       = head(in);
          out_valid_n = 1'b1;
          busy_n      = 1'b1;
          ready_n     = 1'b0;
`ifdef HBIT_SERIALIZER_PARITY_EN
          par_n       = ^in;
`endif
        end
      end
      ST_SHIFT: begin
        busy_n      = 1'b1;
        out_valid_n = 1'b1;
        out_n       = out;
        if (tick_c) begin
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_cnt_n = BW'(WIDTH);
`ifdef HBIT_SERIALIZER_PARITY_EN
            state_n   = ST_PARITY;
            out_n     = par;
`else
            state_n     = ST_DONE;
            out_n       = 1'b0;
            out_valid_n = 1'b0;
            done_n      = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            sr_n      = sr_shift;
            out_n     = head(sr_shift);
          end
        end
      end
`ifdef HBIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        busy_n      = 1'b1;
        out_valid_n = 1'b1;
        out_n       = out;
        if (tick_c) begin
          state_n     = ST_DONE;
          out_n       = 1'b0;
          out_valid_n = 1'b0;
          done_n      = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
`ifdef HBIT_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      sr        <= sr_n;
      bit_cnt   <= bit_cnt_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      ready     <= ready_n;
`ifdef HBIT_SERIALIZER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_hbit_serializer.sv
// Self-checking bench for hbit_serializer: two instances (LSB-first/1 clk,
// MSB-first/3 clk) compared cycle by cycle against a word-level model.
module tb_hbit_serializer;

  localparam int unsigned W = 16;
`ifdef HBIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         load1 = 1'b0, load2 = 1'b0;
  logic         ready1, out1, ov1, busy1, done1;
  logic         ready2, out2, ov2, busy2, done2;

  int checks = 0;
  int failures = 0;

  // {out, out_valid, busy, ready, done} expected per cycle after the accept edge
  logic [4:0] exp_q[$];

  always #5 clock = ~clock;

  hbit_serializer #(.WIDTH(W), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) dut1 (
    .clock(clock), .reset(reset), .in(in1), .load(load1), .ready(ready1),
    .out(out1), .out_valid(ov1), .busy(busy1), .done(done1)
  );

  hbit_serializer #(.WIDTH(W), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1)) dut2 (
    .clock(clock), .reset(reset), .in(in2), .load(load2), .ready(ready2),
    .out(out2), .out_valid(ov2), .busy(busy2), .done(done2)
  );

  function automatic logic [4:0] obs(input bit sel);
    return sel ? {out2, ov2, busy2, ready2, done2} : {out1, ov1, busy1, ready1, done1};
  endfunction

  task automatic set_in(input bit sel, input logic [W-1:0] w, input logic ld);
    if (sel) begin in2 = w; load2 = ld; end
    else     begin in1 = w; load1 = ld; end
  endtask

  // Model: each bit of the word in send order held c cycles, optional even
  // parity bit, then one done cycle and one idle cycle.
  task automatic build_exp(input logic [W-1:0] w, input int c, input bit msb);
    logic b;
    exp_q.delete();
    for (int i = 0; i < int'(W); i++) begin
      b = msb ? w[W-1-i] : w[i];
      for (int j = 0; j < c; j++) exp_q.push_back({b, 4'b1100});
    end
    if (PAR) begin
      b = ^w;
      for (int j = 0; j < c; j++) exp_q.push_back({b, 4'b1100});
    end
    exp_q.push_back(5'b00101);
    exp_q.push_back(5'b00010);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (obs(0) !== 5'b00010) begin
        failures++;
        $display("FAIL reset_idle1 cyc=%0d got=%b exp=%b", k, obs(0), 5'b00010);
      end
      checks++;
      if (obs(1) !== 5'b00010) begin
        failures++;
        $display("FAIL reset_idle2 cyc=%0d got=%b exp=%b", k, obs(1), 5'b00010);
      end
    end
  endtask

  // Single transfer; in is scrambled after capture to show it is not re-read.
  task automatic test_pattern(input bit sel, input logic [W-1:0] word, input string name);
    logic [4:0] got;
    build_exp(word, sel ? 3 : 1, sel);
    @(negedge clock);
    set_in(sel, word, 1'b1);
    @(posedge clock);
    #1 set_in(sel, W'($urandom), 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      got = obs(sel);
      checks++;
      if (got !== exp_q[k]) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, k + 1, got, exp_q[k]);
      end
      set_in(sel, W'($urandom), 1'b0);
    end
  endtask

  task automatic test_ignore_load();
    logic [4:0] got;
    build_exp(16'hA5C3, 1, 1'b0);
    @(negedge clock);
    set_in(0, 16'hA5C3, 1'b1);
    @(posedge clock);
    #1 set_in(0, 16'hA5C3, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      got = obs(0);
      checks++;
      if (got !== exp_q[k]) begin
        failures++;
        $display("FAIL ignore_load cyc=%0d got=%b exp=%b", k + 1, got, exp_q[k]);
      end
      if (k >= 3 && k < 10) set_in(0, 16'hFFFF, 1'b1);
      else                  set_in(0, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    build_exp(16'hA5C3, 1, 1'b0);
    @(negedge clock);
    set_in(0, 16'hA5C3, 1'b1);
    @(posedge clock);
    #1 set_in(0, 16'hA5C3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      got = obs(0);
      checks++;
      if (got !== exp_q[k]) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", k + 1, got, exp_q[k]);
      end
    end
    // bit 7 is on the line now; abort at the next edge
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (obs(0) !== 5'b00010) begin
      failures++;
      $display("FAIL reset_abort got=%b exp=%b", obs(0), 5'b00010);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      checks++;
      if (obs(0) !== 5'b00010) begin
        failures++;
        $display("FAIL reset_no_done cyc=%0d got=%b exp=%b", k, obs(0), 5'b00010);
      end
    end
  endtask

  // load held high throughout: next accept lands after exactly one idle cycle.
  task automatic test_back_to_back(input bit sel, input int n);
    logic [W-1:0] w;
    logic [4:0]   got;
    @(negedge clock);
    w = W'($urandom);
    set_in(sel, w, 1'b1);
    for (int t = 0; t < n; t++) begin
      build_exp(w, sel ? 3 : 1, sel);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clock);
        got = obs(sel);
        checks++;
        if (got !== exp_q[k]) begin
          failures++;
          $display("FAIL back_to_back%0d xfer=%0d cyc=%0d word=%h got=%b exp=%b",
                   sel + 1, t, k + 1, w, got, exp_q[k]);
        end
        if (k == exp_q.size() - 1) begin
          w = W'($urandom);
          set_in(sel, w, (t < n - 1) ? 1'b1 : 1'b0);
        end else begin
          set_in(sel, W'($urandom), 1'b1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(0, 16'hA5C3, "lsb_a5c3");
    test_pattern(0, 16'h0001, "lsb_0001");
    test_pattern(1, 16'h8001, "msb_slow_8001");
    test_pattern(1, 16'hA5C3, "msb_slow_a5c3");
    test_ignore_load();
    test_reset_mid();
    test_back_to_back(0, 8);
    test_back_to_back(1, 4);
    for (int r = 0; r < 4; r++) test_pattern(r[0], W'($urandom), "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbit_serializer.md
Name: hbit_serializer

Overview:
- Read-side counterpart to the loadable bit/word storage elements.
- Accepts a stored WIDTH-bit word on a load strobe and drives it out one bit at a time on a single serial line, with valid framing and a completion pulse.
- Used to drain register/RAM contents to a serial debug or output port of the computer.

Parameters:
- WIDTH, 16, data word width in bits (>=2).
- CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1).
- MSB_FIRST, 0, 0 = shift LSB first; 1 = shift MSB first.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
- load  input  1  request to start a transfer; accepted when load && ready at a rising edge.
- ready  output  1  high when idle and able to accept load.
- out  output  1  serial data bit; 0 whenever out_valid = 0.
- out_valid  output  1  high while a data (or parity) bit is on out.
- busy  output  1  high from the cycle after acceptance until the cycle after done.
- done  output  1  one-cycle pulse after the last bit period ends.

Behaviour:
- Clock and reset: one clock, port name clock; reset is synchronous and active-high, port name reset.
- Reset values: state IDLE, shift register 0, bit and divide counters 0, out=0, out_valid=0, busy=0, done=0, ready=1.
- Reset mid-transfer aborts at the next edge: no done pulse, back to IDLE. Reset has priority over a simultaneous load.
- States: IDLE, SHIFT, PARITY (optional feature only), DONE.
- IDLE:
  - ready=1.
  - On load: capture in, clear counters, go to SHIFT.
  - Next cycle: out = in[0] (or in[WIDTH-1] if MSB_FIRST), out_valid=1, busy=1.
- SHIFT:
  - Each bit is held exactly CLKS_PER_BIT cycles. The divide counter counts 0..CLKS_PER_BIT-1; on wrap the shift register shifts and the bit counter increments.
  - After the last period of bit WIDTH-1: go to PARITY if enabled, else DONE.
- DONE:
  - One cycle with done=1, out_valid=0, out=0, busy=1, ready=0.
  - Then IDLE.
- Latency: accepted load edge to done high = WIDTH*CLKS_PER_BIT + 1 cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back transfers: the earliest next accept is the edge where state = IDLE, one cycle after done. Minimum gap between transfers is 1 idle cycle.
- load while not ready is ignored; a change on in mid-transfer has no effect, because the word is already captured.
- Counter widths: bit counter $clog2(WIDTH+1), divide counter $clog2(CLKS_PER_BIT+1). No wrap beyond their terminal counts.

Optional Feature:
- Macro: HBIT_SERIALIZER_PARITY_EN.
- Defined:
  - After the data bits, PARITY state drives one extra bit for CLKS_PER_BIT cycles with out_valid=1.
  - The bit is even parity, i.e. the XOR of the captured word, computed at capture time.
- Undefined: PARITY state and the parity register are absent; SHIFT goes directly to DONE.

Decomposition:
- Shared include header (guarded like the other sequential-logic headers) holds the state encodings: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3.
- One natural sub-module: hbit_tick, the CLKS_PER_BIT divide counter.
  - Inputs: clock, reset, enable.
  - Output: a one-cycle tick on the last cycle of each bit period.

Test Plan:
- Reset then idle 5 cycles -> ready=1, out=0, out_valid=0, busy=0, done=0 throughout.
- WIDTH=16, CLKS_PER_BIT=1, load in=16'hA5C3 -> out over 16 cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done high exactly 17 cycles after the load edge.
- CLKS_PER_BIT=3, MSB_FIRST=1, in=16'h8001 -> out high for the first 3 cycles, low 42 cycles, high the last 3 cycles; done at cycle 49.
- Load pulsed again and in changed to 16'hFFFF mid-transfer -> output unchanged from the original word; the second load is ignored; ready stays 0 until IDLE.
- reset asserted at bit 7 of a transfer -> next edge: out_valid=0, busy=0, ready=1, and no done pulse ever appears for that transfer.
- With HBIT_SERIALIZER_PARITY_EN, in=16'h0001 -> 16 data bits followed by parity bit 1 with out_valid=1; in=16'hA5C3 -> parity bit 0; done at cycle 18 (CLKS_PER_BIT=1).
